regfile_mp: RTL

Parametrised multi-port general purpose register file. It is the successor to the 2-read/1-write GPR array in the decode stage.
- Configurable width, depth and read/write port counts.
- Per-port write-through bypass with deterministic multi-writer priority.
- Per-register pending scoreboard for the issue logic.
- Sequential clear-on-reset sequencer that zeroes the whole array.
- Feeds operand fetch in ID; written back from WB (one write port per retiring pipe).

---
 rtl/regfile_mp.sv | 115 +++++++++++
 1 files changed

// File: rtl/regfile_mp.sv
// Multi-port register file with same-cycle write bypass, per-register pending
// scoreboard and a sequential zeroing sweep after reset.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     ready,
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR*ADDR_W-1:0] waddr,
  input  logic [NUM_WR*DATA_W-1:0] wdata,
  input  logic [NUM_RD-1:0]        re,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  input  logic                     mark,
  input  logic [ADDR_W-1:0]        mark_addr,
  output logic [NUM_RD-1:0]        busy
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {INIT, RUN} state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   cnt_reg, cnt_next;
  logic [DATA_W-1:0]   regs [DEPTH];
  logic [DEPTH-1:0]    pend_reg, pend_next;
  logic                run;

  // Gate on rst too so outputs drop immediately, not one edge later.
  assign run   = (state_reg == RUN) && !rst;
  assign ready = (state_reg == RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= INIT;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    if (state_reg == INIT) begin
      cnt_next = cnt_reg + 1'b1;
      if (cnt_reg == '1) state_next = RUN;
    end
  end

  // Later loop iterations override earlier ones: highest write port wins.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_reg == INIT) begin
        regs[cnt_reg] <= '0;
      end else begin
        for (int i = 0; i < NUM_WR; i++) begin
          if (we[i] && !(ZERO_REG != 0 && waddr[i*ADDR_W +: ADDR_W] == '0))
            regs[waddr[i*ADDR_W +: ADDR_W]] <= wdata[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) pend_reg <= '0;
    else     pend_reg <= pend_next;
  end

  // Clears first, then the mark: a newer issue outranks a retiring write.
  always_comb begin
    pend_next = pend_reg;
    if (run) begin
      for (int i = 0; i < NUM_WR; i++) begin
        if (we[i]) pend_next[waddr[i*ADDR_W +: ADDR_W]] = 1'b0;
      end
      if (mark) pend_next[mark_addr] = 1'b1;
    end
    if (ZERO_REG != 0) pend_next[0] = 1'b0;
  end

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;
    logic              hit;
    logic              bz;

    assign ra = raddr[gi*ADDR_W +: ADDR_W];

    always_comb begin
      rd  = '0;
      hit = 1'b0;
      bz  = 1'b0;
      if (run && re[gi] && !(ZERO_REG != 0 && ra == '0)) begin
        rd = regs[ra];
        for (int i = 0; i < NUM_WR; i++) begin
          if (we[i] && waddr[i*ADDR_W +: ADDR_W] == ra) begin
            rd  = wdata[i*DATA_W +: DATA_W];
            hit = 1'b1;
          end
        end
        bz = pend_reg[ra] && !hit;
      end
    end

    assign rdata[gi*DATA_W +: DATA_W] = rd;
    assign busy[gi]                   = bz;
  end

endmodule
